// File: rtl/elevator_call_scheduler_if.sv
// Call-scheduler <-> controller/button bundle. master = scheduler side.
interface elevator_call_scheduler_if #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = 5
);
  logic [NUM_FLOORS-1:0] call_btn;
  logic [2:0]            ctrl_state;
  logic [FLOOR_W-1:0]    cur_floor;
  logic [FLOOR_W-1:0]    req_floor;
  logic [NUM_FLOORS-1:0] pending;
  logic                  dir_up;
  logic                  at_floor_ack;
  logic                  fault;

  modport master (
    input  call_btn, ctrl_state, cur_floor,
    output req_floor, pending, dir_up, at_floor_ack, fault
  );
  modport slave (
    output call_btn, ctrl_state, cur_floor,
    input  req_floor, pending, dir_up, at_floor_ack, fault
  );
endinterface

// File: rtl/elevator_call_scheduler.sv
// Debounces floor call buttons, latches pending calls and issues SCAN-ordered
// targets to the elevator controller one request at a time.
module ecs_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], btn};
      if (!sync[1])                          cnt <= '0;
      else if (cnt != CW'(DEBOUNCE_CYCLES))  cnt <= cnt + CW'(1);
    end
  end

  // Fires on the cycle the counter saturates: the 0->1 edge of the debounced level.
  assign rise = sync[1] && (cnt == CW'(DEBOUNCE_CYCLES - 1));
endmodule

module elevator_call_scheduler #(
  parameter int NUM_FLOORS      = 8,
  parameter int FLOOR_W         = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACK_TIMEOUT     = 16
) (
  input logic                       clk,
  input logic                       reset,
  elevator_call_scheduler_if.master bus
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [2:0] CTRL_IDLE   = 3'b000;
  localparam logic [2:0] CTRL_MOVING = 3'b001;
  localparam logic [2:0] CTRL_STOP   = 3'b010;

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, WAIT_ARRIVE} state_t;

  state_t                state, state_n;
  logic [NUM_FLOORS-1:0] pend, pend_n, set_vec, here_mask, stop_clr, sel_clr;
  logic [FLOOR_W-1:0]    req, req_n, cur_eff, up_tgt, dn_tgt;
  logic [TW-1:0]         tmo, tmo_n;
  logic                  dir, dir_n, ack, ack_n, flt, flt_n;
  logic                  cur_ok, here_hit, up_found, dn_found;
  logic [NUM_FLOORS-1:0] btn;

  assign btn = bus.call_btn;

  ecs_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_FLOORS-1:0] (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .rise  (set_vec)
  );

  // Out-of-range car positions never clear locally and select as floor 0.
  assign cur_ok  = (bus.cur_floor >= FLOOR_W'(1)) && (bus.cur_floor <= FLOOR_W'(NUM_FLOORS));
  assign cur_eff = cur_ok ? bus.cur_floor : '0;

  always_comb begin
    here_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++)
      here_mask[i] = cur_ok && (bus.cur_floor == FLOOR_W'(i + 1));
  end

  assign stop_clr = (bus.ctrl_state == CTRL_STOP) ? here_mask : '0;
  assign here_hit = |(pend & here_mask);

  // Nearest pending floor above (lowest wins) and below (highest wins).
  always_comb begin
    up_found = 1'b0;
    up_tgt   = '0;
    dn_found = 1'b0;
    dn_tgt   = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (pend[i] && (FLOOR_W'(i + 1) > cur_eff)) begin
        up_found = 1'b1;
        up_tgt   = FLOOR_W'(i + 1);
      end
    for (int i = 0; i < NUM_FLOORS; i++)
      if (pend[i] && (FLOOR_W'(i + 1) < cur_eff)) begin
        dn_found = 1'b1;
        dn_tgt   = FLOOR_W'(i + 1);
      end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pend  <= '0;
      req   <= '0;
      dir   <= 1'b1;
      ack   <= 1'b0;
      flt   <= 1'b0;
      tmo   <= '0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      req   <= req_n;
      dir   <= dir_n;
      ack   <= ack_n;
      flt   <= flt_n;
      tmo   <= tmo_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:
        if ((|pend) && (bus.ctrl_state == CTRL_IDLE)) state_n = SELECT;
      SELECT:
        if (here_hit)                 state_n = SELECT;
        else if (up_found || dn_found) state_n = ISSUE;
        else                          state_n = IDLE;
      ISSUE:
        if (bus.ctrl_state == CTRL_MOVING)        state_n = WAIT_ARRIVE;
        else if (tmo == TW'(ACK_TIMEOUT - 1))      state_n = IDLE;
      WAIT_ARRIVE:
        if ((bus.ctrl_state == CTRL_IDLE) && (bus.cur_floor == req)) state_n = SELECT;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    req_n   = req;
    dir_n   = dir;
    ack_n   = 1'b0;
    flt_n   = flt;
    tmo_n   = tmo;
    sel_clr = '0;
    case (state)
      SELECT: begin
        tmo_n = '0;
        if (here_hit) begin
          ack_n   = 1'b1;
          sel_clr = here_mask;
        end else if (dir) begin
          if (up_found)      req_n = up_tgt;
          else if (dn_found) begin req_n = dn_tgt; dir_n = 1'b0; end
        end else begin
          if (dn_found)      req_n = dn_tgt;
          else if (up_found) begin req_n = up_tgt; dir_n = 1'b1; end
        end
      end
      ISSUE:
        if (bus.ctrl_state != CTRL_MOVING) begin
          if (tmo == TW'(ACK_TIMEOUT - 1)) flt_n = 1'b1;
          else                             tmo_n = tmo + TW'(1);
        end
      default: ;
    endcase
    // A fresh press beats a same-cycle clear; the call is served again later.
    pend_n = (pend & ~(stop_clr | sel_clr)) | set_vec;
  end

  assign bus.req_floor    = req;
  assign bus.pending      = pend;
  assign bus.dir_up       = dir;
  assign bus.at_floor_ack = ack;
  assign bus.fault        = flt;
endmodule
